// File: rtl/seven_segment_defs_pkg.sv
// rtl/seven_segment_defs_pkg.sv - glyph table and segment bit indices shared with the display driver
// Glyphs are 7-bit a..g with a in bit 6; pin bus bits follow SEG_A..SEG_DP.
package seven_segment_defs;

   localparam logic [6:0] GLYPH_0 = 7'h7E;
   localparam logic [6:0] GLYPH_1 = 7'h30;
   localparam logic [6:0] GLYPH_2 = 7'h6D;
   localparam logic [6:0] GLYPH_3 = 7'h79;
   localparam logic [6:0] GLYPH_4 = 7'h33;
   localparam logic [6:0] GLYPH_5 = 7'h5B;
   localparam logic [6:0] GLYPH_6 = 7'h5F;
   localparam logic [6:0] GLYPH_7 = 7'h70;
   localparam logic [6:0] GLYPH_8 = 7'h7F;
   localparam logic [6:0] GLYPH_9 = 7'h7B;
   localparam logic [6:0] GLYPH_A = 7'h77;
   localparam logic [6:0] GLYPH_B = 7'h1F;
   localparam logic [6:0] GLYPH_C = 7'h4E;
   localparam logic [6:0] GLYPH_D = 7'h3D;
   localparam logic [6:0] GLYPH_E = 7'h4F;
   localparam logic [6:0] GLYPH_F = 7'h47;

   localparam int SEG_A  = 7;
   localparam int SEG_B  = 6;
   localparam int SEG_C  = 5;
   localparam int SEG_D  = 4;
   localparam int SEG_E  = 3;
   localparam int SEG_F  = 2;
   localparam int SEG_G  = 1;
   localparam int SEG_DP = 0;

   typedef struct packed {
      logic       valid;
      logic [3:0] nibble;
   } glyph_result_t;

   function automatic logic [6:0] glyph_of(input logic [3:0] n);
      case (n)
         4'h0:    glyph_of = GLYPH_0;
         4'h1:    glyph_of = GLYPH_1;
         4'h2:    glyph_of = GLYPH_2;
         4'h3:    glyph_of = GLYPH_3;
         4'h4:    glyph_of = GLYPH_4;
         4'h5:    glyph_of = GLYPH_5;
         4'h6:    glyph_of = GLYPH_6;
         4'h7:    glyph_of = GLYPH_7;
         4'h8:    glyph_of = GLYPH_8;
         4'h9:    glyph_of = GLYPH_9;
         4'hA:    glyph_of = GLYPH_A;
         4'hB:    glyph_of = GLYPH_B;
         4'hC:    glyph_of = GLYPH_C;
         4'hD:    glyph_of = GLYPH_D;
         4'hE:    glyph_of = GLYPH_E;
         default: glyph_of = GLYPH_F;
      endcase
   endfunction

endpackage

// File: rtl/seven_segment_glyph_decoder.sv
// rtl/seven_segment_glyph_decoder.sv - combinational 7-bit glyph to {valid, nibble}
// Unknown glyphs return valid=0 with nibble 0.
module seven_segment_glyph_decoder
   import seven_segment_defs::*;
(
   input  logic [6:0]    glyph,
   output glyph_result_t result
);

   always_comb begin
      result = '0;
      for (int i = 0; i < 16; i++) begin
         if (glyph == glyph_of(4'(i))) begin
            result.valid  = 1'b1;
            result.nibble = 4'(i);
         end
      end
   end

endmodule

// File: rtl/seven_segment_scan_decoder.sv
// rtl/seven_segment_scan_decoder.sv - rebuilds hex frames from a scanned 7-segment LED bus
// Define SEVEN_SEGMENT_SCAN_ACTIVE_LOW_EN for common-anode panels (both buses inverted).
module seven_segment_scan_decoder
   import seven_segment_defs::*;
#(
   parameter int WIDTH_NIBBLES = 6,
   parameter int SETTLE_CYCLES = 4,
   parameter int IDLE_CYCLES   = 65536
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [7:0]                 led_segments,
   input  logic [WIDTH_NIBBLES-1:0]   segment_enable,
   output logic [WIDTH_NIBBLES*4-1:0] data,
   output logic [WIDTH_NIBBLES-1:0]   digit_present,
   output logic [WIDTH_NIBBLES-1:0]   decimal_point,
   output logic [WIDTH_NIBBLES-1:0]   pattern_error,
   output logic                       frame_valid
);

   localparam int W   = WIDTH_NIBBLES;
   localparam int STW = $clog2(SETTLE_CYCLES + 1);
   localparam int IDW = $clog2(IDLE_CYCLES);
   localparam logic [STW-1:0] SETTLE_MAX = STW'(SETTLE_CYCLES);
   localparam logic [IDW-1:0] IDLE_MAX   = IDW'(IDLE_CYCLES - 1);

   logic [7:0]     seg_s1, seg_s2, seg_q, prev_seg;
   logic [W-1:0]   en_s1, en_s2, en_q, prev_en;
   logic           en_one_hot, qualify, capture, wrap, flush, publish;
   logic           armed;
   logic [STW-1:0] stable_cnt;
   logic [IDW-1:0] idle_cnt;
   logic [W*4-1:0] sh_data, data_next;
   logic [W-1:0]   seen, sh_dp, sh_err;
   logic [W-1:0]   seen_next, dp_next, err_next, cap_mask;
   glyph_result_t  dec;

   always_ff @(posedge clk) begin
      if (reset) begin
         seg_s1   <= '0;
         seg_s2   <= '0;
         en_s1    <= '0;
         en_s2    <= '0;
         prev_seg <= '0;
         prev_en  <= '0;
      end else begin
         seg_s1   <= led_segments;
         seg_s2   <= seg_s1;
         en_s1    <= segment_enable;
         en_s2    <= en_s1;
         prev_seg <= seg_q;
         prev_en  <= en_q;
      end
   end

`ifdef SEVEN_SEGMENT_SCAN_ACTIVE_LOW_EN
   assign seg_q = ~seg_s2;
   assign en_q  = ~en_s2;
`else
   assign seg_q = seg_s2;
   assign en_q  = en_s2;
`endif

   assign en_one_hot = (en_q != '0) && ((en_q & (en_q - W'(1))) == '0);
   assign qualify    = en_one_hot && (seg_q == prev_seg) && (en_q == prev_en);

   // prev_* still hold the settled sample when the count saturates, so capture from them.
   assign capture  = (stable_cnt == SETTLE_MAX) && !armed;
   assign cap_mask = capture ? prev_en : '0;
   assign wrap     = |(prev_en & seen);
   assign flush    = !capture && (idle_cnt == IDLE_MAX) && (seen != '0);
   assign publish  = (capture && wrap) || flush;

   seven_segment_glyph_decoder u_glyph (
      .glyph  (prev_seg[SEG_A:SEG_G]),
      .result (dec)
   );

   // A publish empties the shadow before the capturing digit is loaded into it.
   always_comb begin
      seen_next = publish ? '0 : seen;
      dp_next   = publish ? '0 : sh_dp;
      err_next  = publish ? '0 : sh_err;
      data_next = publish ? '0 : sh_data;
      seen_next = seen_next | cap_mask;
      dp_next   = (dp_next & ~cap_mask) | (cap_mask & {W{prev_seg[SEG_DP]}});
      err_next  = (err_next & ~cap_mask) | (cap_mask & {W{~dec.valid}});
      for (int i = 0; i < W; i++) begin
         if (cap_mask[i]) begin
            data_next[i*4 +: 4] = dec.nibble;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stable_cnt    <= '0;
         armed         <= 1'b0;
         idle_cnt      <= '0;
         seen          <= '0;
         sh_dp         <= '0;
         sh_err        <= '0;
         sh_data       <= '0;
         data          <= '0;
         digit_present <= '0;
         decimal_point <= '0;
         pattern_error <= '0;
         frame_valid   <= 1'b0;
      end else begin
         if (!qualify) begin
            stable_cnt <= '0;
            armed      <= 1'b0;
         end else begin
            if (stable_cnt != SETTLE_MAX) begin
               stable_cnt <= stable_cnt + STW'(1);
            end
            if (capture) begin
               armed <= 1'b1;
            end
         end

         if (capture) begin
            idle_cnt <= '0;
         end else if (idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + IDW'(1);
         end

         seen    <= seen_next;
         sh_dp   <= dp_next;
         sh_err  <= err_next;
         sh_data <= data_next;

         frame_valid <= publish;
         if (publish) begin
            data          <= sh_data;
            digit_present <= seen;
            decimal_point <= sh_dp;
            pattern_error <= sh_err;
         end
      end
   end

endmodule
